aes_frame_loader: RTL and testbench

- Upstream feeder for aes_top: assembles a UART receive byte stream into 128-bit key and plaintext operands and launches one encryption per frame.
- Sits between the UART receiver (one-cycle byte strobe) and aes_top (i_key/i_plain/start), replacing the hard-coded operand registers in the FPGA top.
- Frames are header-tagged. An inter-byte timeout discards partial frames. Status flags report framing errors and overruns.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_byte_shifter.sv | 21 ++
 rtl/aes_frame_loader.sv | 136 +++++++++++++
 tb/tb_aes_frame_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants for the AES operand loader: FSM encoding, frame headers and block geometry.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    localparam logic [7:0] HDR_FULL_DEFAULT  = 8'hA5;
    localparam logic [7:0] HDR_PLAIN_DEFAULT = 8'hA6;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_KEY       = 3'd1;
    localparam logic [2:0] S_PLAIN     = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    // Bit 0 is the MSB, matching aes_top operand numbering
    typedef logic [0:AES_BLOCK_BITS-1] aes_block_t;

endpackage

// File: rtl/aes_byte_shifter.sv
// 16-byte operand register; byte idx lands in bits [8*idx : 8*idx+7], byte 0 being the MSB byte.
module aes_byte_shifter
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] idx,
    input  logic [7:0] data_in,
    output aes_block_t block
);

    always_ff @(posedge clk) begin
        if (rst) begin
            block <= '0;
        end else if (we) begin
            block[{idx, 3'b000} +: 8] <= data_in;
        end
    end

endmodule

// File: rtl/aes_frame_loader.sv
// Assembles header-tagged UART byte frames into AES key/plaintext operands and launches aes_top.
module aes_frame_loader
    import aes_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 10_000_000,
    parameter logic [7:0] HDR_FULL       = HDR_FULL_DEFAULT,
    parameter logic [7:0] HDR_PLAIN      = HDR_PLAIN_DEFAULT
) (
    input  logic         i_clock,
    input  logic         i_rst,
    input  logic         i_rx_valid,
    input  logic [7:0]   i_rx_byte,
    input  logic         i_aes_done,
    output logic [0:127] o_key,
    output logic [0:127] o_plain,
    output logic         o_start,
    output logic         o_busy,
    output logic         o_key_valid,
    output logic         o_err,
    output logic         o_overrun
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

    logic [2:0]       state;
    logic [3:0]       byte_idx;
    logic [CNT_W-1:0] timer;
    logic             done_prev;
    logic             key_we;
    logic             plain_we;

    assign key_we   = i_rx_valid && (state == S_KEY);
    assign plain_we = i_rx_valid && (state == S_PLAIN);

    aes_byte_shifter u_key_reg (
        .clk     (i_clock),
        .rst     (i_rst),
        .we      (key_we),
        .idx     (byte_idx),
        .data_in (i_rx_byte),
        .block   (o_key)
    );

    aes_byte_shifter u_plain_reg (
        .clk     (i_clock),
        .rst     (i_rst),
        .we      (plain_we),
        .idx     (byte_idx),
        .data_in (i_rx_byte),
        .block   (o_plain)
    );

    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            state       <= S_IDLE;
            byte_idx    <= '0;
            timer       <= '0;
            done_prev   <= 1'b0;
            o_start     <= 1'b0;
            o_busy      <= 1'b0;
            o_key_valid <= 1'b0;
            o_err       <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_start <= 1'b0;
            o_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_byte == HDR_FULL) begin
                            state    <= S_KEY;
                            byte_idx <= '0;
                            timer    <= '0;
                            o_busy   <= 1'b1;
                        end else if (i_rx_byte == HDR_PLAIN) begin
                            if (o_key_valid) begin
                                state    <= S_PLAIN;
                                byte_idx <= '0;
                                timer    <= '0;
                                o_busy   <= 1'b1;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                    end
                end
                S_KEY, S_PLAIN: begin
                    // A byte on the expiry cycle takes priority over the timeout
                    if (i_rx_valid) begin
                        timer <= '0;
                        if (byte_idx == LAST_IDX) begin
                            byte_idx <= '0;
                            if (state == S_KEY) begin
                                o_key_valid <= 1'b1;
                                state       <= S_PLAIN;
                            end else begin
                                state   <= S_START;
                                o_start <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end else if (timer == CNT_LAST) begin
                        o_err  <= 1'b1;
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_START: begin
                    done_prev <= i_aes_done;
                    state     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    done_prev <= i_aes_done;
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (i_aes_done && !done_prev) begin
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed plus randomized frame bench for aes_frame_loader with a frame-level reference model.
module tb_aes_frame_loader;

    localparam int TIMEOUT = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         aes_done;
    logic [0:127] key;
    logic [0:127] plain;
    logic         start;
    logic         busy;
    logic         key_valid;
    logic         err;
    logic         overrun;

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_key;
    logic         exp_key_valid;
    logic         exp_overrun;

    localparam logic [127:0] FIPS_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PLAIN = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] REUSE_PLAIN = 128'h00112233445566778899aabbccddeeff;

    aes_frame_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .i_clock     (clk),
        .i_rst       (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .i_aes_done  (aes_done),
        .o_key       (key),
        .o_plain     (plain),
        .o_start     (start),
        .o_busy      (busy),
        .o_key_valid (key_valid),
        .o_err       (err),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle_cycles(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // One-cycle byte strobe; returns at the negedge after the sampling edge
    task automatic apply_stimulus(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] blk, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(blk[127 - 8*i -: 8]);
            if (i < 15 && max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_key       = '0;
        exp_key_valid = 1'b0;
        exp_overrun   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_key"}, key, '0);
        check_output({tag, "_plain"}, plain, '0);
        check_output({tag, "_start"}, start, 1'b0);
        check_output({tag, "_busy"}, busy, 1'b0);
        check_output({tag, "_kvalid"}, key_valid, 1'b0);
        check_output({tag, "_err"}, err, 1'b0);
        check_output({tag, "_overrun"}, overrun, 1'b0);
    endtask

    // aes_top stand-in: done rises after a delay, busy must drop one cycle later
    task automatic finish_encryption(input string tag, input int delay);
        repeat (delay) @(negedge clk);
        check_output({tag, "_busy_before_done"}, busy, 1'b1);
        aes_done = 1'b1;
        @(negedge clk);
        check_output({tag, "_busy_after_done"}, busy, 1'b0);
        check_output({tag, "_overrun_after_done"}, overrun, exp_overrun);
        @(negedge clk);
        aes_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] r_key;
        logic [127:0] r_plain;
        logic [7:0]   g;
        logic         full;

        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        aes_done = 1'b0;
        @(negedge clk);

        do_reset();
        check_reset_state("reset");

        apply_stimulus(8'h00);
        check_output("garbage00_err", err, 1'b0);
        apply_stimulus(8'hFF);
        check_output("garbageFF_err", err, 1'b0);
        check_output("garbage_busy", busy, 1'b0);

        apply_stimulus(8'hA6);
        check_output("nokey_a6_err", err, 1'b1);
        check_output("nokey_a6_busy", busy, 1'b0);
        idle_cycles(1);
        check_output("nokey_err_pulse", err, 1'b0);
        check_output("nokey_no_start", start, 1'b0);

        // Reset in the middle of a key
        apply_stimulus(8'hA5);
        for (int i = 0; i < 7; i++) apply_stimulus(FIPS_KEY[127 - 8*i -: 8]);
        check_output("midframe_busy", busy, 1'b1);
        do_reset();
        check_reset_state("midframe_reset");

        // FIPS-197 frame
        apply_stimulus(8'hA5);
        check_output("fips_busy_hdr", busy, 1'b1);
        send_block(FIPS_KEY, 0);
        check_output("fips_kvalid", key_valid, 1'b1);
        check_output("fips_no_early_start", start, 1'b0);
        send_block(FIPS_PLAIN, 0);
        exp_key = FIPS_KEY;
        exp_key_valid = 1'b1;
        check_output("fips_start", start, 1'b1);
        check_output("fips_key", key, FIPS_KEY);
        check_output("fips_plain", plain, FIPS_PLAIN);
        idle_cycles(1);
        check_output("fips_start_pulse", start, 1'b0);
        finish_encryption("fips", 19);

        // Stored key reuse
        apply_stimulus(8'hA6);
        check_output("reuse_err", err, 1'b0);
        check_output("reuse_busy", busy, 1'b1);
        send_block(REUSE_PLAIN, 3);
        check_output("reuse_start", start, 1'b1);
        check_output("reuse_key", key, FIPS_KEY);
        check_output("reuse_plain", plain, REUSE_PLAIN);
        idle_cycles(1);
        check_output("reuse_start_pulse", start, 1'b0);
        exp_overrun = 1'b1;
        apply_stimulus(8'h5C);
        check_output("overrun_set", overrun, 1'b1);
        check_output("overrun_busy", busy, 1'b1);
        finish_encryption("overrun", 5);
        check_output("overrun_sticky", overrun, 1'b1);

        // Inter-byte timeout
        do_reset();
        apply_stimulus(8'hA5);
        for (int i = 0; i < 5; i++) apply_stimulus(8'h10 + 8'(i));
        idle_cycles(TIMEOUT - 1);
        check_output("timeout_not_yet_err", err, 1'b0);
        check_output("timeout_not_yet_busy", busy, 1'b1);
        idle_cycles(1);
        check_output("timeout_err", err, 1'b1);
        check_output("timeout_busy", busy, 1'b0);
        check_output("timeout_kvalid", key_valid, 1'b0);
        idle_cycles(1);
        check_output("timeout_err_pulse", err, 1'b0);

        // Byte on the expiry cycle wins
        apply_stimulus(8'hA5);
        for (int i = 0; i < 5; i++) apply_stimulus(8'h20 + 8'(i));
        idle_cycles(TIMEOUT - 1);
        apply_stimulus(8'h77);
        check_output("expiry_byte_err", err, 1'b0);
        check_output("expiry_byte_busy", busy, 1'b1);
        check_output("expiry_byte_written", key[40:47], 8'h77);
        idle_cycles(TIMEOUT);
        check_output("expiry_later_timeout", err, 1'b1);

        // Randomized frames against the frame-level model
        do_reset();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom);
                if (g == 8'hA5 || g == 8'hA6) g = 8'h00;
                apply_stimulus(g);
                check_output("rand_garbage_err", err, 1'b0);
            end
            r_key   = {$urandom, $urandom, $urandom, $urandom};
            r_plain = {$urandom, $urandom, $urandom, $urandom};
            full    = !exp_key_valid || ($urandom_range(0, 1) == 1);
            apply_stimulus(full ? 8'hA5 : 8'hA6);
            idle_cycles($urandom_range(0, 10));
            if (full) begin
                send_block(r_key, 20);
                exp_key = r_key;
                exp_key_valid = 1'b1;
                idle_cycles($urandom_range(0, 10));
            end
            send_block(r_plain, 20);
            check_output("rand_start", start, 1'b1);
            check_output("rand_key", key, exp_key);
            check_output("rand_plain", plain, r_plain);
            check_output("rand_kvalid", key_valid, exp_key_valid);
            idle_cycles(1);
            check_output("rand_start_pulse", start, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                apply_stimulus(8'($urandom));
                exp_overrun = 1'b1;
            end
            check_output("rand_overrun", overrun, exp_overrun);
            finish_encryption("rand", $urandom_range(1, 30));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
